// File: rtl/edac_pkg.sv
// edac_pkg: shared definitions for the EDAC background scrubber.
//   DATA_BITS            width of the EDAC data bus (E0D/E1D/E2D, EDO, SWD)
//   DEF_*                default scrub timing constants
//   scrub_state_t        scrubber FSM state encoding
package edac_pkg;

    localparam int DATA_BITS        = 8;

    localparam int DEF_INTERVAL     = 1000;
    localparam int DEF_READ_CYCLES  = 3;
    localparam int DEF_WRITE_CYCLES = 2;

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_NEXT  = 2'd3
    } scrub_state_t;

endpackage

// File: rtl/scrub_timer.sv
// scrub_timer: loadable down-counter with hold and zero flag.
//   clk       system clock
//   rst       synchronous active-high reset, loads RST_VAL
//   load      load load_val (has priority over dec)
//   load_val  value to load
//   dec       decrement by one; ignored once the count reaches zero
//   zero      count is zero
module scrub_timer #(
    parameter int WIDTH   = 10,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst)
            count <= WIDTH'(RST_VAL);
        else if (load)
            count <= load_val;
        else if (dec && (count != '0))
            count <= count - WIDTH'(1);
    end

    assign zero = (count == '0);

endmodule

// File: rtl/edac_scrubber.sv
// edac_scrubber: background scrubber for the triple-redundant EDAC memory.
// Reads each word through the voter during CPU-idle gaps and writes the
// corrected word back to all banks when the voter flags a disagreement.
//   CLK         system clock
//   RESET       synchronous active-high reset
//   ENABLE      scrubbing permitted
//   CPU_IDLE    no CPU memory access in progress
//   EDO         voted/corrected data from the EDAC
//   ERR_DET_C   voter disagreement flag, valid with EDO
//   CLR         one-cycle pulse clearing CORR_COUNT
//   SA          scrub address
//   SOWN        scrubber owns the memory bus
//   SRD / SWR   active-high read / write strobes
//   SWD         write-back data
//   CORR_COUNT  saturating count of corrected words
//   PASS_DONE   one-cycle pulse when SA wraps to 0
module edac_scrubber
    import edac_pkg::*;
#(
    parameter int ADDR_BITS    = 15,
    parameter int MEM_WORDS    = 32768,
    parameter int INTERVAL     = DEF_INTERVAL,
    parameter int READ_CYCLES  = DEF_READ_CYCLES,
    parameter int WRITE_CYCLES = DEF_WRITE_CYCLES,
    parameter int COUNT_BITS   = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  ENABLE,
    input  logic                  CPU_IDLE,
    input  logic [DATA_BITS-1:0]  EDO,
    input  logic                  ERR_DET_C,
    input  logic                  CLR,
    output logic [ADDR_BITS-1:0]  SA,
    output logic                  SOWN,
    output logic                  SRD,
    output logic                  SWR,
    output logic [DATA_BITS-1:0]  SWD,
    output logic [COUNT_BITS-1:0] CORR_COUNT,
    output logic                  PASS_DONE
);

    localparam int T_RW   = (READ_CYCLES > WRITE_CYCLES) ? READ_CYCLES : WRITE_CYCLES;
    localparam int T_MAX  = (INTERVAL > T_RW) ? INTERVAL : T_RW;
    localparam int TW     = $clog2(T_MAX + 1);
    localparam logic [COUNT_BITS-1:0] CNT_MAX = '1;

    scrub_state_t   state;
    logic           tmr_load;
    logic [TW-1:0]  tmr_val;
    logic           tmr_dec;
    logic           tmr_zero;
    logic           abort;
    logic           inc;
    logic           last_word;

    // One timer serves both the idle interval and the strobe widths; strobe
    // phases load (width-1) so the zero flag marks the final strobe cycle.
    // The interval is loaded on entry to NEXT, so the NEXT cycle counts as
    // the first idle cycle and an access recurs every INTERVAL+READ_CYCLES+1.
    scrub_timer #(.WIDTH(TW), .RST_VAL(INTERVAL)) u_timer (
        .clk      (CLK),
        .rst      (RESET),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_comb begin
        abort     = ((state == S_READ) || (state == S_WRITE)) && (!CPU_IDLE || !ENABLE);
        inc       = (state == S_WRITE) && !abort && tmr_zero;
        last_word = (SA == ADDR_BITS'(MEM_WORDS - 1));
        tmr_load  = 1'b0;
        tmr_val   = '0;
        tmr_dec   = 1'b0;
        case (state)
            S_WAIT: begin
                if (!tmr_zero)
                    tmr_dec = ENABLE;
                else if (ENABLE && CPU_IDLE) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(READ_CYCLES - 1);
                end
            end
            S_READ: begin
                if (abort) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(1);
                end else if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = ERR_DET_C ? TW'(WRITE_CYCLES - 1) : TW'(INTERVAL);
                end else
                    tmr_dec = 1'b1;
            end
            S_WRITE: begin
                if (abort) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(1);
                end else if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(INTERVAL);
                end else
                    tmr_dec = 1'b1;
            end
            S_NEXT:  tmr_dec = ENABLE;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= S_WAIT;
            SA         <= '0;
            SOWN       <= 1'b0;
            SRD        <= 1'b0;
            SWR        <= 1'b0;
            SWD        <= '0;
            CORR_COUNT <= '0;
            PASS_DONE  <= 1'b0;
        end else begin
            PASS_DONE <= 1'b0;
            case (state)
                S_WAIT: begin
                    if (tmr_zero && ENABLE && CPU_IDLE) begin
                        state <= S_READ;
                        SOWN  <= 1'b1;
                        SRD   <= 1'b1;
                    end
                end
                S_READ: begin
                    if (abort) begin
                        state <= S_WAIT;
                        SOWN  <= 1'b0;
                        SRD   <= 1'b0;
                    end else if (tmr_zero) begin
                        SWD <= EDO;
                        SRD <= 1'b0;
                        if (ERR_DET_C) begin
                            // Bus ownership carries straight over into the write-back.
                            state <= S_WRITE;
                            SWR   <= 1'b1;
                        end else begin
                            state     <= S_NEXT;
                            SOWN      <= 1'b0;
                            SA        <= last_word ? '0 : SA + ADDR_BITS'(1);
                            PASS_DONE <= last_word;
                        end
                    end
                end
                S_WRITE: begin
                    if (abort) begin
                        // SA is kept so the same word is re-read and re-voted.
                        state <= S_WAIT;
                        SOWN  <= 1'b0;
                        SWR   <= 1'b0;
                    end else if (tmr_zero) begin
                        state     <= S_NEXT;
                        SOWN      <= 1'b0;
                        SWR       <= 1'b0;
                        SA        <= last_word ? '0 : SA + ADDR_BITS'(1);
                        PASS_DONE <= last_word;
                    end
                end
                S_NEXT:  state <= S_WAIT;
                default: state <= S_WAIT;
            endcase

            // Clear takes effect before a coincident increment.
            if (CLR)
                CORR_COUNT <= inc ? COUNT_BITS'(1) : '0;
            else if (inc && (CORR_COUNT != CNT_MAX))
                CORR_COUNT <= CORR_COUNT + COUNT_BITS'(1);
        end
    end

endmodule

// File: doc/edac_scrubber.md
Name: edac_scrubber

Overview:
- Background scrubber for the triple-redundant EDAC memory. Sits beside the CPU on the E0D/E1D/E2D bus, in the same clock domain as the HULOGIC EDAC datapath.
- Walks every memory word during CPU-idle gaps and reads it through the voter (corrected data plus error flag).
- When the voter reports a disagreement, writes the corrected word back to all three banks. This stops single-bank upsets from accumulating into uncorrectable double upsets.

Parameters:
ADDR_BITS, 15, width of scrub address
MEM_WORDS, 32768, words per pass; address wraps at MEM_WORDS-1
INTERVAL, 1000, idle CLK cycles between scrub accesses (>=1)
READ_CYCLES, 3, cycles SRD held per read (>=2)
WRITE_CYCLES, 2, cycles SWR held per write-back (>=1)
COUNT_BITS, 8, width of corrected-word counter

Ports:
CLK  in  1  system clock (CPU CLKOUT, 7.4 MHz)
RESET  in  1  synchronous, active-high reset
ENABLE  in  1  scrubbing permitted
CPU_IDLE  in  1  high when no nIOCS/nECS access is active
EDO  in  8  voted/corrected data from EDAC
ERR_DET_C  in  1  voter disagreement flag, valid with EDO
CLR  in  1  one-cycle pulse: clear CORR_COUNT
SA  out  ADDR_BITS  scrub address to memory address mux
SOWN  out  1  scrubber owns memory bus (address mux select)
SRD  out  1  active-high read strobe
SWR  out  1  active-high write strobe
SWD  out  8  write-back data
CORR_COUNT  out  COUNT_BITS  corrected words, saturating
PASS_DONE  out  1  one-cycle pulse when address wraps to 0

Behaviour:
- All outputs are registered. Reset values: SA=0, SOWN=0, SRD=0, SWR=0, SWD=0, CORR_COUNT=0, PASS_DONE=0. After reset the state is WAIT and the timer is loaded with INTERVAL.
- WAIT: the timer decrements every cycle while ENABLE=1 and holds while ENABLE=0. At timer 0 with CPU_IDLE=1, go to READ. At timer 0 with CPU_IDLE=0, stay in WAIT at 0 until CPU_IDLE=1.
- READ: SOWN=1, SRD=1 for READ_CYCLES cycles. In the last cycle, capture EDO into SWD and latch ERR_DET_C. Next state is WRITE if the latched flag is 1, otherwise NEXT.
- WRITE: SOWN=1, SWR=1 for WRITE_CYCLES cycles, with SWD stable throughout. Then go to NEXT and increment CORR_COUNT.
- NEXT (1 cycle): SOWN=0. SA increments, or wraps from MEM_WORDS-1 to 0 with PASS_DONE=1 in the same cycle. Timer reloads with INTERVAL. Go to WAIT.
- SOWN asserts in the same cycle SRD first asserts and drops in the cycle after the last strobe.
- Abort: if CPU_IDLE=0 or ENABLE=0 during READ or WRITE, then on the next edge SRD, SWR and SOWN go to 0 and the state goes to WAIT with timer=1. SA, CORR_COUNT and SWD are unchanged, so the same address is re-read later from READ.
- An aborted write is never counted. The partial write is safe because the next read re-votes the word.
- CPU priority: the CPU always wins. The scrubber never asserts SOWN while CPU_IDLE=0.
- ENABLE=0 in WAIT freezes the timer and SA. No strobes are issued.
- CORR_COUNT saturates at 2^COUNT_BITS-1.
- If CLR and an increment occur in the same cycle, CORR_COUNT becomes 1 (the clear applies first, then the increment).
- Reset mid-operation: strobes drop on the reset edge and the block returns to the reset values. No partial-state retention.
- Latency, uninterrupted and error-free: one access every INTERVAL+READ_CYCLES+1 cycles. With an error: add WRITE_CYCLES.

Decomposition:
- Shared package edac_pkg holds:
  - state encoding localparams (S_WAIT, S_READ, S_WRITE, S_NEXT);
  - DATA_BITS=8;
  - default timing constants.
- One natural sub-module, scrub_timer: a loadable down-counter with hold and zero flag, reused for the interval count and the strobe-width count.
- The FSM and counters stay in edac_scrubber.

Test Plan:
- Reset, ENABLE=1, CPU_IDLE=1, INTERVAL=4, no errors -> first SRD rises 5 cycles after reset release and lasts 3 cycles. SA steps 0,1,2 at 8-cycle spacing. SWR never asserted; CORR_COUNT=0.
- ERR_DET_C=1 with EDO=8'hA5 in the last READ cycle at SA=7 -> SWR high 2 cycles with SWD=8'hA5 and SA=7. CORR_COUNT becomes 1. Next read is at SA=8.
- CPU_IDLE falls in the 2nd READ cycle at SA=3 -> SRD and SOWN are 0 next cycle. When CPU_IDLE returns, SA=3 is re-read; CORR_COUNT is unchanged.
- MEM_WORDS=4, run 4 accesses -> SA wraps 3->0 with PASS_DONE high for exactly 1 cycle. Repeat shows the wrap is periodic.
- COUNT_BITS=2, force 5 errors -> CORR_COUNT holds at 3. CLR coincident with a 6th write-back -> CORR_COUNT=1.
- RESET asserted mid-WRITE -> SWR, SOWN=0 on that edge. All outputs return to reset values; the first access after release is at SA=0.
